alu_arbiter: RTL and testbench

Shares one combinational 32-bit `alu` instance between two requesters (port 0, port 1) using round-robin arbitration. Each accepted request is latched, driven onto the ALU for one cycle, and the captured result and flags are returned to the owning requester. The block sits between the ALU and its clients, so several datapath stages can reuse one ALU without contention logic of their own.

---
 rtl/alu_arbiter_if.sv | 57 +++++
 rtl/alu_arbiter.sv | 104 ++++++++++
 tb/tb_alu_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side bundle for the two-port ALU arbiter.
// The slave view belongs to the arbiter; the master view to clients plus ALU.
interface alu_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
);
    logic             req0_valid;
    logic             req1_valid;
    logic             req0_ready;
    logic             req1_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_b;
    logic [OPW-1:0]   req0_op;
    logic [OPW-1:0]   req1_op;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp0_res;
    logic [WIDTH-1:0] rsp1_res;
    logic             rsp0_zero;
    logic             rsp1_zero;
    logic             rsp0_ovf;
    logic             rsp1_ovf;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             alu_ovf;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_a, req1_a, req0_b, req1_b,
        input  req0_op, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid,
        output rsp0_res, rsp1_res,
        output rsp0_zero, rsp1_zero,
        output rsp0_ovf, rsp1_ovf,
        output alu_a, alu_b, alu_op,
        input  alu_res, alu_zero, alu_ovf
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_a, req1_a, req0_b, req1_b,
        output req0_op, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid,
        input  rsp0_res, rsp1_res,
        input  rsp0_zero, rsp1_zero,
        input  rsp0_ovf, rsp1_ovf,
        input  alu_a, alu_b, alu_op,
        output alu_res, alu_zero, alu_ovf
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Each grant runs IDLE -> EXEC -> RESP, so one operation per three cycles.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_prio;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic             w_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_hs;

    // Grants are mutually exclusive: a tie goes to the port named by r_prio.
    assign w_idle = (r_state == IDLE);
    assign w_gnt0 = w_idle & bus.req0_valid & (~r_prio | ~bus.req1_valid);
    assign w_gnt1 = w_idle & bus.req1_valid & (r_prio | ~bus.req0_valid);
    assign w_hs   = w_gnt0 | w_gnt1;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_hs) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio  <= 1'b0;
            r_owner <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
        end else if (w_hs) begin
            r_a     <= w_gnt1 ? bus.req1_a  : bus.req0_a;
            r_b     <= w_gnt1 ? bus.req1_b  : bus.req0_b;
            r_op    <= w_gnt1 ? bus.req1_op : bus.req0_op;
            r_owner <= w_gnt1;
            r_prio  <= w_gnt0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res  <= '0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (r_state == EXEC) begin
                r_res  <= bus.alu_res;
                r_zero <= bus.alu_zero;
                r_ovf  <= bus.alu_ovf;
            end
            if (r_state == RESP) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.alu_a      = r_a;
    assign bus.alu_b      = r_b;
    assign bus.alu_op     = r_op;
    assign bus.rsp0_valid = (r_state == RESP) & ~r_owner;
    assign bus.rsp1_valid = (r_state == RESP) & r_owner;
    assign bus.rsp0_res   = r_res;
    assign bus.rsp1_res   = r_res;
    assign bus.rsp0_zero  = r_zero;
    assign bus.rsp1_zero  = r_zero;
    assign bus.rsp0_ovf   = r_ovf;
    assign bus.rsp1_ovf   = r_ovf;
    assign busy           = ~w_idle;
    assign done_cnt       = r_cnt;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU and arbiter model.
// Counter width is reduced to 2 bits so wrap-around is exercised.
module tb_alu_arbiter;
    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [1:0] done_cnt;

    alu_arbiter_if #(.WIDTH(32), .OPW(3)) ifc ();

    alu_arbiter #(.WIDTH(32), .OPW(3), .CNT_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (ifc),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    typedef struct {
        int          port;
        logic [31:0] res;
        logic        z;
        logic        o;
    } exp_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t rsp_log[$];
    int   grants[$];
    int   mbusy;
    logic mprio;
    logic [1:0] mcnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: 0 and, 1 or, 2 add (ovf=carry), 3 xor, 4 shl, 5 shr, 6 sub (ovf=borrow), 7 slt
    function automatic logic [33:0] alu_f(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] t;
        logic [31:0] r;
        logic        ov;
        t  = '0;
        ov = 1'b0;
        r  = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin t = {1'b0, a} + {1'b0, b}; r = t[31:0]; ov = t[32]; end
            3'd3: r = a ^ b;
            3'd4: r = a << b[10:6];
            3'd5: r = a >> b[10:6];
            3'd6: begin t = {1'b0, a} - {1'b0, b}; r = t[31:0]; ov = t[32]; end
            default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        return {(r == 32'd0), ov, r};
    endfunction

    always_comb begin
        {ifc.alu_zero, ifc.alu_ovf, ifc.alu_res} = alu_f(ifc.alu_op, ifc.alu_a, ifc.alu_b);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: independent timing model of grant, response and count.
    initial begin
        mbusy = 0;
        mprio = 1'b0;
        mcnt  = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                mbusy = 0;
                mprio = 1'b0;
                mcnt  = 2'd0;
                chk("rst_rsp0_valid", 64'(ifc.rsp0_valid), 64'd0);
                chk("rst_rsp1_valid", 64'(ifc.rsp1_valid), 64'd0);
            end else begin
                logic idle, r0, r1, v0, v1;
                exp_t e;
                v0   = ifc.req0_valid;
                v1   = ifc.req1_valid;
                idle = (mbusy == 0);
                r0   = idle & v0 & (!mprio | !v1);
                r1   = idle & v1 & (mprio | !v0);
                chk("busy", 64'(busy), 64'(!idle));
                chk("ready0", 64'(ifc.req0_ready), 64'(r0));
                chk("ready1", 64'(ifc.req1_ready), 64'(r1));
                chk("ready_excl", 64'(ifc.req0_ready & ifc.req1_ready), 64'd0);
                chk("done_cnt", 64'(done_cnt), 64'(mcnt));
                if (ifc.rsp0_valid | ifc.rsp1_valid) begin
                    e.port = ifc.rsp1_valid ? 1 : 0;
                    e.res  = ifc.rsp1_valid ? ifc.rsp1_res  : ifc.rsp0_res;
                    e.z    = ifc.rsp1_valid ? ifc.rsp1_zero : ifc.rsp0_zero;
                    e.o    = ifc.rsp1_valid ? ifc.rsp1_ovf  : ifc.rsp0_ovf;
                    rsp_log.push_back(e);
                end
                if (mbusy == 1 && q.size() > 0) begin
                    e = q.pop_front();
                    chk("rsp0_valid", 64'(ifc.rsp0_valid), 64'(e.port == 0));
                    chk("rsp1_valid", 64'(ifc.rsp1_valid), 64'(e.port == 1));
                    if (e.port == 0) begin
                        chk("rsp0_res", 64'(ifc.rsp0_res), 64'(e.res));
                        chk("rsp0_zero", 64'(ifc.rsp0_zero), 64'(e.z));
                        chk("rsp0_ovf", 64'(ifc.rsp0_ovf), 64'(e.o));
                    end else begin
                        chk("rsp1_res", 64'(ifc.rsp1_res), 64'(e.res));
                        chk("rsp1_zero", 64'(ifc.rsp1_zero), 64'(e.z));
                        chk("rsp1_ovf", 64'(ifc.rsp1_ovf), 64'(e.o));
                    end
                    mcnt = mcnt + 2'd1;
                end else begin
                    chk("rsp0_idle", 64'(ifc.rsp0_valid), 64'd0);
                    chk("rsp1_idle", 64'(ifc.rsp1_valid), 64'd0);
                end
                if (mbusy > 0) mbusy--;
                if (ifc.req0_ready & v0) grants.push_back(0);
                if (ifc.req1_ready & v1) grants.push_back(1);
                if (r0 | r1) begin
                    logic [33:0] f;
                    f = r1 ? alu_f(ifc.req1_op, ifc.req1_a, ifc.req1_b)
                           : alu_f(ifc.req0_op, ifc.req0_a, ifc.req0_b);
                    e.port = r1 ? 1 : 0;
                    e.z    = f[33];
                    e.o    = f[32];
                    e.res  = f[31:0];
                    q.push_back(e);
                    mprio = r0;
                    mbusy = 2;
                end
            end
        end
    end

    task automatic idle_inputs();
        ifc.req0_valid = 1'b0;
        ifc.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drive(input int p, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            ifc.req0_valid = 1'b1;
            ifc.req0_op = op;
            ifc.req0_a = a;
            ifc.req0_b = b;
        end else begin
            ifc.req1_valid = 1'b1;
            ifc.req1_op = op;
            ifc.req1_a = a;
            ifc.req1_b = b;
        end
    endtask

    // Issue one op, check grant-to-response latency, return captured response.
    task automatic do_op(input int p, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output logic o);
        int k;
        int j;
        logic got;
        res = '0;
        z   = 1'b0;
        o   = 1'b0;
        @(posedge clk);
        #1;
        drive(p, op, a, b);
        got = 1'b0;
        for (k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = (p == 0) ? ifc.req0_ready : ifc.req1_ready;
        end
        chk("grant_timeout", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        got = 1'b0;
        for (j = 1; j <= 6 && !got; j++) begin
            @(negedge clk);
            got = (p == 0) ? ifc.rsp0_valid : ifc.rsp1_valid;
            if (got) begin
                chk("latency", 64'(j), 64'd2);
                res = (p == 0) ? ifc.rsp0_res  : ifc.rsp1_res;
                z   = (p == 0) ? ifc.rsp0_zero : ifc.rsp1_zero;
                o   = (p == 0) ? ifc.rsp0_ovf  : ifc.rsp1_ovf;
            end
        end
        chk("rsp_timeout", 64'(got), 64'd1);
    endtask

    initial begin
        logic [31:0] res;
        logic        z;
        logic        o;
        logic [1:0]  wrap_exp [5];
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst_n = 1'b0;
        ifc.req0_a = '0; ifc.req0_b = '0; ifc.req0_op = '0;
        ifc.req1_a = '0; ifc.req1_b = '0; ifc.req1_op = '0;
        idle_inputs();
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done_cnt), 64'd0);
        chk("reset_alu_op", 64'(ifc.alu_op), 64'd0);
        chk("reset_res", 64'(ifc.rsp0_res), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Contention: both ports valid for 12 cycles from reset.
        grants.delete();
        rsp_log.delete();
        drive(0, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0);
        drive(1, 3'b001, 32'hF0F0F0F0, 32'h0FF00FF0);
        repeat (12) @(posedge clk);
        #1;
        idle_inputs();
        repeat (4) @(posedge clk);
        chk("rr_count", 64'(grants.size() >= 4), 64'd1);
        chk("rr_rsp_count", 64'(rsp_log.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < grants.size() && i < rsp_log.size(); i++) begin
            chk("rr_grant", 64'(grants[i]), 64'(i % 2));
            chk("rr_rsp_port", 64'(rsp_log[i].port), 64'(i % 2));
            chk("rr_rsp_res", 64'(rsp_log[i].res),
                (i % 2 == 0) ? 64'h00F000F0 : 64'hFFF0FFF0);
        end

        do_reset();
        do_op(0, 3'b010, 32'hFFFFFFFF, 32'h00000001, res, z, o);
        chk("add_res", 64'(res), 64'h0);
        chk("add_zero", 64'(z), 64'd1);
        chk("add_ovf", 64'(o), 64'd1);
        @(negedge clk);
        chk("add_done", 64'(done_cnt), 64'd1);

        do_op(1, 3'b110, 32'd5, 32'd5, res, z, o);
        chk("sub_res", 64'(res), 64'h0);
        chk("sub_zero", 64'(z), 64'd1);
        chk("sub_ovf", 64'(o), 64'd0);

        do_op(0, 3'b101, 32'hF0000000, 32'h00000100, res, z, o);
        chk("shr_res", 64'(res), 64'h0F000000);
        chk("shr_zero", 64'(z), 64'd0);

        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_op(i % 2, 3'($urandom_range(0, 7)), $urandom, $urandom, res, z, o);
            @(negedge clk);
            chk("wrap_done", 64'(done_cnt), 64'(wrap_exp[i]));
        end

        // Reset while an operation is in EXEC.
        @(posedge clk);
        #1;
        drive(0, 3'b011, 32'h12345678, 32'h0F0F0F0F);
        @(negedge clk);
        chk("inflight_grant", 64'(ifc.req0_ready), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("inflight_busy", 64'(busy), 64'd0);
        chk("inflight_alu_op", 64'(ifc.alu_op), 64'd0);
        chk("inflight_alu_a", 64'(ifc.alu_a), 64'd0);
        chk("inflight_res", 64'(ifc.rsp0_res), 64'd0);
        chk("inflight_done", 64'(done_cnt), 64'd0);
        chk("inflight_rsp0", 64'(ifc.rsp0_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 3'b001, 32'h00000001, 32'h00000002);
        @(negedge clk);
        chk("post_rst_grant1", 64'(ifc.req1_ready), 64'd1);
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (4) @(posedge clk);

        // Random traffic checked entirely by the scoreboard.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            ifc.req0_valid = ($urandom_range(0, 3) != 0);
            ifc.req1_valid = ($urandom_range(0, 3) != 0);
            ifc.req0_op = 3'($urandom_range(0, 7));
            ifc.req1_op = 3'($urandom_range(0, 7));
            ifc.req0_a = $urandom;
            ifc.req0_b = $urandom;
            ifc.req1_a = $urandom;
            ifc.req1_b = $urandom;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        repeat (6) @(posedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
